// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core load/store path.
//
// Accepts one word-sized load or store per transaction, waits LATENCY
// cycles, performs the access on an internal word array, then holds the
// response until the initiator takes it. `done` pulses in the cycle the
// response handshake completes and serves as the mem-stage unpause.
//
// Handshake rules (both channels): a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge. Once raised,
// rsp_valid and its payload stay stable until rsp_ready is seen. The
// responder only looks at req_valid in IDLE and only looks at rsp_ready
// in RESP.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   req_valid  request present            req_ready  request can be accepted
//   req_we     1 = store, 0 = load        req_addr   byte address
//   req_wdata  store data                 req_wstrb  store byte enables
//   rsp_valid  response present           rsp_ready  initiator takes response
//   rsp_rdata  load data (0 for stores/errors)
//   rsp_err    misaligned or out-of-range request
//   done       one-cycle pulse on response handshake
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 ACCESS, 3 RESP)
module dmem_responder #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_wstrb,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            done,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic       LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  we_q, we_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  addr_err;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] idx;

    logic [XLEN-1:0]       mem [2**ADDR_WIDTH];

    // State register and all other control/response flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;

    // Next-state logic and wait-state counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LAT_ZERO) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // Counter reaches 1 on the last wait cycle.
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address checks use only the latched request.
    assign idx      = addr_q[ADDR_WIDTH+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      ((addr_q >> (ADDR_WIDTH + 2)) != '0);
    assign mem_we   = (state_q == S_ACCESS) && we_q && !addr_err;

    // Output / datapath logic.
    always_comb begin
        // req_ready is registered so it stays low during reset and rises
        // on the first edge after release.
        req_ready_d = (state_d == S_IDLE);
        we_d        = accept ? req_we    : we_q;
        addr_d      = accept ? req_addr  : addr_q;
        wdata_d     = accept ? req_wdata : wdata_q;
        wstrb_d     = accept ? req_wstrb : wstrb_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (state_q == S_ACCESS) begin
            err_d   = addr_err;
            rdata_d = (!addr_err && !we_q) ? mem[idx] : '0;
        end
    end

    // Storage: no reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end

    // rsp_valid and done derive from state, so reset drops them at once.
    assign req_ready = req_ready_q;
    assign rsp_valid = (state_q == S_RESP);
    assign done      = (state_q == S_RESP) && rsp_ready;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err, done;
    logic [31:0] rsp_rdata;
    logic [1:0]  dbg_state;

    // Second instance built with LATENCY=0.
    logic        z_req_valid, z_req_we, z_rsp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_wstrb;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_done;
    logic [31:0] z_rsp_rdata;
    logic [1:0]  z_dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_responder #(.XLEN(32), .ADDR_WIDTH(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .done(done), .dbg_state(dbg_state)
    );

    dmem_responder #(.XLEN(32), .ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .done(z_done), .dbg_state(z_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    // ---------------- driver: one full transaction on u_dut ----------------
    task automatic do_txn(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int dones);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: req_ready never rose");
        end
        @(posedge clk);           // accept edge
        lat = 1;
        #1;
        // Scramble inputs after acceptance; they must have no effect.
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom_range(0, 15));
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        dones = 0;
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        #1;
        if (done) dones++;
        @(negedge clk);
        if (done) dones++;
        rsp_ready = 1'b0;
    endtask

    // ---------------- driver: one transaction on u_dut0 ----------------
    task automatic do_txn0(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output int lat);
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr;
        z_req_wdata = wdata; z_req_wstrb = 4'hF; z_rsp_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        while (!z_rsp_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        rdata = z_rsp_rdata;
        z_rsp_ready = 1'b1;
        @(negedge clk);
        z_rsp_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t        vecs[11];
        logic [31:0] rd, held;
        logic        er;
        int          lat, dn;

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b0, 32'h12,   32'h0,        4'hF, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h0,    32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h0,    32'h0,        4'h0, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 32'h2,    32'h0,        4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h0,    32'h0,        4'hF, 32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'h20,   32'h12345678, 4'hF, 32'h0,        1'b0};

        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 0; req_wdata = 0;
        req_wstrb = 0; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 0; z_req_wdata = 0;
        z_req_wstrb = 0; z_rsp_ready = 1'b0;

        // Reset held with req_valid high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_done",      {31'b0, done},      32'h0);
        check("rst_rdata",     rsp_rdata,          32'h0);
        check("rst_err",       {31'b0, rsp_err},   32'h0);
        req_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b1;
        #1 check("rel_ready_before_edge", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        check("rel_ready_after_edge", {31'b0, req_ready}, 32'h1);

        // Table-driven transactions.
        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                   rd, er, lat, dn);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_done_pulses", i), dn, 1);
        end

        // Backpressure: hold rsp_ready low 5 cycles in RESP.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
        @(posedge clk);
        #1 req_addr = 32'h0;       // req_valid stays high: must be ignored
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("bp_latency", lat, 4);
        held = rsp_rdata;
        check("bp_rdata", held, 32'hDE22BE44);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", c), {31'b0, rsp_valid}, 32'h1);
            check($sformatf("bp_stable_%0d", c), rsp_rdata, held);
            check($sformatf("bp_ready_%0d", c), {31'b0, req_ready}, 32'h0);
            check($sformatf("bp_done_%0d", c), {31'b0, done}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1 check("bp_done_pulse", {31'b0, done}, 32'h1);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_done_after", {31'b0, done}, 32'h0);
        check("bp_idle_ready", {31'b0, req_ready}, 32'h1);
        check("bp_idle_state", {30'b0, dbg_state}, 32'h0);

        // Reset abort during WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wait", {30'b0, dbg_state}, 32'h1);
        rst = 1'b0;
        #1;
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_done", {31'b0, done}, 32'h0);
        end
        rst = 1'b1;
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, dn);
        check("abort_load_rdata", rd, 32'h12345678);
        check("abort_load_done", dn, 1);

        // LATENCY=0 instance.
        do_txn0(1'b1, 32'h8, 32'h00C0FFEE, rd, lat);
        check("lat0_store_latency", lat, 2);
        do_txn0(1'b0, 32'h8, 32'h0, rd, lat);
        check("lat0_load_latency", lat, 2);
        check("lat0_load_rdata", rd, 32'h00C0FFEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's load/store path. Accepts one word-sized load or store request per transaction through a valid/ready handshake, models a configurable number of wait states, then accesses an internal word array and returns read data with a valid/ready response handshake. Sits between the mem stage (initiator) and storage, and produces the one-cycle done pulse that the ctrl block uses as the mem unpause signal.

Parameters:
XLEN, 32, data and address width in bits
ADDR_WIDTH, 10, log2 of word count; array holds 2^ADDR_WIDTH words
LATENCY, 2, wait-state cycles between request accept and access; legal range 0..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data
req_wstrb  input  4  byte enables for a store; bit i enables byte lane i
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts the response
rsp_rdata  output  XLEN  load data; 0 for stores and errors
rsp_err  output  1  request was misaligned or out of range
done  output  1  one-cycle pulse when the response handshake completes (unpause)

Behaviour:
- Reset: clk and rst are the single clock and reset; rst is asynchronous and active-low. While rst=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, done=0, wait counter=0. First cycle after release: req_ready=1. Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata/wstrb. If LATENCY=0, go to ACCESS; otherwise load counter=LATENCY and go to WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle; at counter=1, go to ACCESS.
  - ACCESS (one cycle): perform the access, register the response, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready=1. On rsp_valid&rsp_ready: done=1 for exactly that cycle and state returns to IDLE.
- Latency: rsp_valid rises LATENCY+2 cycles after the accept edge. The minimum transaction is LATENCY+3 cycles, including the IDLE return. No back-to-back acceptance; req_ready is low from accept until IDLE.
- Address decoding:
  - Word index = addr[ADDR_WIDTH+1:2].
  - Misaligned if addr[1:0]!=0.
  - Out of range if any addr bit above ADDR_WIDTH+1 is nonzero.
  - On either error: rsp_err=1, rsp_rdata=0, and no array write occurs.
- Store: in ACCESS, each enabled byte lane is written; disabled lanes are preserved. wstrb=0 is a legal no-op store, rsp_err=0. rsp_rdata=0.
- Load: rsp_rdata = full word at the index, sampled in ACCESS. wstrb is ignored.
- Ordering: a store commits in its ACCESS cycle, so any later load returns the new data.
- Inputs are sampled only at the accept edge. Changes to req_* afterwards have no effect.
- Reset mid-transaction: an abort from IDLE/WAIT discards the request and no write occurs. A write already committed in ACCESS persists. rsp_valid and done drop immediately and asynchronously.
- rsp_ready asserted outside RESP is ignored. req_valid asserted outside IDLE is ignored (not queued).
- done never asserts without a completed response handshake.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, done=0. After release, req_ready=1 on the next edge.
- Full store then load, LATENCY=2: store addr 0x10, data 0xDEADBEEF, wstrb=0xF; then load 0x10 with rsp_ready=1 -> rdata=0xDEADBEEF, err=0. rsp_valid appears 4 cycles after each accept; done pulses once per transaction.
- Byte strobes: after the previous store, store 0x11223344 with wstrb=0x5 to 0x10, then load -> rdata=0xDE22BE44.
- Errors: load 0x12 -> err=1, rdata=0. Store to 0x1000 (ADDR_WIDTH=10) -> err=1. A subsequent load of index 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rdata stable, req_ready=0, done=0. Raise rsp_ready -> single done pulse, then IDLE. LATENCY=0 build: rsp_valid appears 2 cycles after accept.
- Reset abort: accept store 0x20/0xCAFEF00D; pull rst low in WAIT. After release, load 0x20 -> previous contents unchanged, no done pulse for the aborted request.
